// File: rtl/bg_ovl_pkg.sv
// Shared types and word layout for the background overlay fetch block.
package bg_ovl_pkg;

    typedef enum logic [1:0] {
        MODE_FG    = 2'd0,
        MODE_KEY   = 2'd1,
        MODE_BLEND = 2'd2,
        MODE_BG    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

    // Background word layout: {B,A,R,G}, one nibble each
    localparam int B_LSB = 12;
    localparam int A_LSB = 8;
    localparam int R_LSB = 4;
    localparam int G_LSB = 0;

    function automatic logic [3:0] get_nib(input logic [15:0] w, input int lsb);
        return w[lsb +: 4];
    endfunction

endpackage

// File: rtl/bg_fifo.sv
// Show-ahead synchronous FIFO with synchronous clear; clear wins over push/pop.
module bg_fifo
    import bg_ovl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                       clk_sys,
    input  logic                       RESET_L,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full && !clr;
    assign do_rd   = rd_en && !empty && !clr;
    assign rd_data = mem[rd_ptr];

    // Storage array, no reset needed since reads are qualified by count
    always_ff @(posedge clk_sys) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk_sys or negedge RESET_L) begin
        if (!RESET_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bg_overlay_fetch.sv
// Background overlay: prefetches 16-bit background words from memory into a
// FIFO and composites them with the foreground pixel stream.
//
// state | meaning
// IDLE  | disabled or waiting for the first frame start
// FETCH | may issue a request when the FIFO has room
// WAIT  | one request outstanding, waiting for mem_ack
// DONE  | whole frame requested, waiting for the next frame start
module bg_overlay_fetch
    import bg_ovl_pkg::*;
#(
    parameter int                H_ACTIVE  = 640,
    parameter int                V_ACTIVE  = 480,
    parameter int                CW        = 4,
    parameter int                DEPTH     = 16,
    parameter int                ADDR_W    = 25,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_sys,
    input  logic              RESET_L,
    input  logic              ce_pix,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              vs,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [3*CW-1:0]   fg_rgb,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_data,
    output logic [3*CW-1:0]   rgb_out,
    output logic              underflow,
    output logic [7:0]        underflow_cnt
);
    localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int          WCW   = $clog2(TOTAL + 1);
    localparam int          CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state;
    logic              vs_prev;
    logic              discard;
    logic [ADDR_W-1:0] frame_addr;
    logic [WCW-1:0]    words_req;

    logic              vs_rise;
    logic              flush;
    logic              push;
    logic              pix_act;
    logic              pop;
    logic              room;
    logic [15:0]       fifo_rd_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign vs_rise = vs && !vs_prev;
    assign flush   = vs_rise || !enable;
    assign push    = mem_req && mem_ack && (state == WAIT) && !discard && !vs_rise && enable;
    assign pix_act = ce_pix && !hblank && !vblank;
    assign pop     = pix_act && enable;
    assign room    = !fifo_full && ((fifo_count + CNT_W'(mem_req)) < CNT_W'(DEPTH));

    bg_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
        .clk_sys (clk_sys),
        .RESET_L (RESET_L),
        .clr     (flush),
        .wr_en   (push),
        .wr_data (mem_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Fetch sequencing; mem_addr only changes when a new request is issued so
    // it stays stable for the whole handshake, even across a frame restart
    always_ff @(posedge clk_sys or negedge RESET_L) begin
        if (!RESET_L) begin
            state      <= IDLE;
            vs_prev    <= 1'b0;
            discard    <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= BASE_ADDR;
            frame_addr <= BASE_ADDR;
            words_req  <= '0;
        end else begin
            vs_prev <= vs;
            if (!enable) begin
                state      <= IDLE;
                discard    <= 1'b0;
                mem_req    <= 1'b0;
                mem_addr   <= BASE_ADDR;
                frame_addr <= BASE_ADDR;
                words_req  <= '0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (vs_rise) begin
                            state      <= FETCH;
                            frame_addr <= BASE_ADDR;
                            words_req  <= '0;
                        end
                    end
                    FETCH: begin
                        if (vs_rise) begin
                            frame_addr <= BASE_ADDR;
                            words_req  <= '0;
                        end else if (words_req == WCW'(TOTAL)) begin
                            state <= DONE;
                        end else if (room) begin
                            mem_req   <= 1'b1;
                            mem_addr  <= frame_addr;
                            words_req <= words_req + 1'b1;
                            state     <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            discard <= 1'b0;
                            state   <= FETCH;
                            if (vs_rise) begin
                                frame_addr <= BASE_ADDR;
                                words_req  <= '0;
                            end else if (!discard) begin
                                frame_addr <= frame_addr + ADDR_W'(2);
                            end
                        end else if (vs_rise) begin
                            discard    <= 1'b1;
                            frame_addr <= BASE_ADDR;
                            words_req  <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    function automatic logic [CW-1:0] expand(input logic [3:0] n);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < CW; i++) r[CW-1-i] = n[3-(i%4)];
        return r;
    endfunction

    function automatic logic [CW-1:0] blend(input logic [CW-1:0] f,
                                            input logic [CW-1:0] b,
                                            input logic [3:0]    a);
        logic [CW+4:0] s;
        s = (CW+5)'(f) * (CW+5)'(5'd16 - {1'b0, a}) + (CW+5)'(b) * (CW+5)'(a);
        return s[CW+3:4];
    endfunction

    logic [15:0]     bg_word;
    logic [3:0]      alpha;
    logic [3*CW-1:0] bg_rgb;
    logic [3*CW-1:0] mix;
    mode_e           eff_mode;

    assign bg_word  = (enable && !fifo_empty) ? fifo_rd_data : 16'h0000;
    assign alpha    = get_nib(bg_word, A_LSB);
    assign bg_rgb   = {expand(get_nib(bg_word, R_LSB)),
                       expand(get_nib(bg_word, G_LSB)),
                       expand(get_nib(bg_word, B_LSB))};
    assign eff_mode = enable ? mode_e'(mode) : MODE_FG;

    // Per-pixel composite of foreground and background
    always_comb begin
        mix = fg_rgb;
        case (eff_mode)
            MODE_FG:  mix = fg_rgb;
            MODE_KEY: mix = ((fg_rgb != '0) && (alpha == 4'd0)) ? fg_rgb : bg_rgb;
            MODE_BLEND: begin
                for (int c = 0; c < 3; c++)
                    mix[c*CW +: CW] = blend(fg_rgb[c*CW +: CW], bg_rgb[c*CW +: CW], alpha);
            end
            MODE_BG:  mix = bg_rgb;
            default:  mix = fg_rgb;
        endcase
    end

    // Registered pixel output plus underflow reporting, advanced by ce_pix
    always_ff @(posedge clk_sys or negedge RESET_L) begin
        if (!RESET_L) begin
            rgb_out       <= '0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            underflow <= 1'b0;
            if (ce_pix) rgb_out <= pix_act ? mix : '0;
            if (pop && fifo_empty) begin
                underflow <= 1'b1;
                if (underflow_cnt != 8'hFF) underflow_cnt <= underflow_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bg_overlay_fetch.sv
// Directed bench for bg_overlay_fetch: frame fill, composite modes, underflow,
// frame restart with a late ack, enable gating, and a small-frame instance.
module tb_bg_overlay_fetch;
    import bg_ovl_pkg::*;

    localparam int CW = 4;

    logic        clk_sys = 1'b0;
    logic        RESET_L;
    logic        ce_pix, hblank, vblank, vs, enable;
    logic [1:0]  mode;
    logic [11:0] fg_rgb;
    logic        ack_en;
    logic [15:0] mem_word;

    logic        mem_req, mem_ack;
    logic [24:0] mem_addr;
    logic [11:0] rgb_out;
    logic        underflow;
    logic [7:0]  underflow_cnt;

    logic        mem_req2, mem_ack2;
    logic [24:0] mem_addr2;
    logic [11:0] rgb_out2;
    logic        underflow2;
    logic [7:0]  underflow_cnt2;

    int n_chk  = 0;
    int n_fail = 0;
    int n_small = 0;

    always #5 clk_sys = ~clk_sys;

    assign mem_ack  = ack_en && mem_req;
    assign mem_ack2 = mem_req2;

    always @(posedge clk_sys) if (mem_req2) n_small++;

    bg_overlay_fetch dut (
        .clk_sys(clk_sys), .RESET_L(RESET_L), .ce_pix(ce_pix), .hblank(hblank),
        .vblank(vblank), .vs(vs), .enable(enable), .mode(mode), .fg_rgb(fg_rgb),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_word),
        .rgb_out(rgb_out), .underflow(underflow), .underflow_cnt(underflow_cnt)
    );

    bg_overlay_fetch #(.H_ACTIVE(4), .V_ACTIVE(2)) u_small (
        .clk_sys(clk_sys), .RESET_L(RESET_L), .ce_pix(ce_pix), .hblank(hblank),
        .vblank(vblank), .vs(vs), .enable(enable), .mode(mode), .fg_rgb(fg_rgb),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_data(mem_word),
        .rgb_out(rgb_out2), .underflow(underflow2), .underflow_cnt(underflow_cnt2)
    );

    typedef struct {
        logic [15:0] word;
        logic [1:0]  md;
        logic [11:0] fg;
        logic        hb;
        logic        vb;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t vec [12];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Restart the frame with a new constant memory word and wait for a full FIFO
    task automatic load_word(input logic [15:0] w);
        int k;
        ack_en = 1'b0; mem_word = w; ce_pix = 1'b0; vblank = 1'b1;
        vs = 1'b0; tick();
        vs = 1'b1; tick();
        vs = 1'b0; ack_en = 1'b1;
        k = 0;
        while (dut.fifo_count != 5'd16 && k < 80) begin
            tick();
            k++;
        end
        check("load_fill", 32'(dut.fifo_count), 32'd16);
    endtask

    initial begin
        logic [24:0] addrs [4];
        logic [15:0] cur_word;
        int n_hs;
        int n_uf;

        vec[0]  = '{16'hF0F0, 2'd0, 12'h123, 1'b0, 1'b0, 12'h123};
        vec[1]  = '{16'hF0F0, 2'd1, 12'h000, 1'b0, 1'b0, 12'hF0F};
        vec[2]  = '{16'hF0F0, 2'd1, 12'h123, 1'b0, 1'b0, 12'h123};
        vec[3]  = '{16'hF0F0, 2'd2, 12'h123, 1'b0, 1'b0, 12'h123};
        vec[4]  = '{16'hF0F0, 2'd3, 12'h123, 1'b0, 1'b0, 12'hF0F};
        vec[5]  = '{16'hF0F0, 2'd3, 12'h123, 1'b1, 1'b0, 12'h000};
        vec[6]  = '{16'h0800, 2'd2, 12'h888, 1'b0, 1'b0, 12'h444};
        vec[7]  = '{16'h0800, 2'd1, 12'h888, 1'b0, 1'b0, 12'h000};
        vec[8]  = '{16'h0800, 2'd0, 12'h888, 1'b0, 1'b0, 12'h888};
        vec[9]  = '{16'h5A3C, 2'd2, 12'hF00, 1'b0, 1'b0, 12'h773};
        vec[10] = '{16'h5A3C, 2'd3, 12'hF00, 1'b0, 1'b0, 12'h3C5};
        vec[11] = '{16'h5A3C, 2'd3, 12'hF00, 1'b0, 1'b1, 12'h000};

        RESET_L = 1'b0; ce_pix = 1'b0; hblank = 1'b1; vblank = 1'b1; vs = 1'b0;
        enable = 1'b0; mode = 2'd0; fg_rgb = 12'h000; ack_en = 1'b0; mem_word = 16'hF0F0;
        repeat (3) tick();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_rgb_out", 32'(rgb_out), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_underflow_cnt", 32'(underflow_cnt), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_fifo_count", 32'(dut.fifo_count), 32'd0);

        // First frame: fill from BASE_ADDR until the FIFO is full
        RESET_L = 1'b1; enable = 1'b1;
        repeat (2) tick();
        vs = 1'b1; tick();
        vs = 1'b0; ack_en = 1'b1;
        n_hs = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (mem_req) begin
                if (n_hs < 4) addrs[n_hs] = mem_addr;
                n_hs++;
            end
        end
        check("fill_addr0", 32'(addrs[0]), 32'd0);
        check("fill_addr1", 32'(addrs[1]), 32'd2);
        check("fill_addr2", 32'(addrs[2]), 32'd4);
        check("fill_addr3", 32'(addrs[3]), 32'd6);
        check("fill_words", 32'(n_hs), 32'd16);
        check("fill_count", 32'(dut.fifo_count), 32'd16);
        check("fill_stalled", 32'(mem_req), 32'd0);
        check("small_words", 32'(n_small), 32'd8);
        check("small_state", 32'(u_small.state), 32'(DONE));
        check("small_req", 32'(mem_req2), 32'd0);
        check("small_addr_last", 32'(mem_addr2), 32'd14);

        // Composite vectors, one active pixel each, refill in between
        cur_word = 16'hF0F0;
        for (int i = 0; i < 12; i++) begin
            if (vec[i].word != cur_word) begin
                load_word(vec[i].word);
                cur_word = vec[i].word;
            end
            mode = vec[i].md; fg_rgb = vec[i].fg;
            hblank = vec[i].hb; vblank = vec[i].vb; ce_pix = 1'b1;
            tick();
            ce_pix = 1'b0; hblank = 1'b1; vblank = 1'b1;
            check($sformatf("vec%0d_rgb", i), 32'(rgb_out), 32'(vec[i].exp_rgb));
            repeat (4) tick();
        end

        // Withhold acks for 40 active pixels: 16 good pops then 24 underflows
        ack_en = 1'b0;
        repeat (2) tick();
        check("uf_pre_count", 32'(dut.fifo_count), 32'd16);
        n_uf = 0;
        for (int i = 0; i < 40; i++) begin
            hblank = 1'b0; vblank = 1'b0; ce_pix = 1'b1;
            tick();
            if (underflow) n_uf++;
            ce_pix = 1'b0;
            tick();
            if (underflow) n_uf++;
        end
        check("uf_pulses", 32'(n_uf), 32'd24);
        check("uf_cnt24", 32'(underflow_cnt), 32'd24);
        check("uf_fifo_empty", 32'(dut.fifo_count), 32'd0);
        for (int i = 0; i < 240; i++) begin
            ce_pix = 1'b1; tick();
            ce_pix = 1'b0; tick();
        end
        check("uf_cnt_sat", 32'(underflow_cnt), 32'd255);
        ce_pix = 1'b1; tick(); ce_pix = 1'b0; tick();
        check("uf_cnt_hold", 32'(underflow_cnt), 32'd255);

        // Frame restart while a request is outstanding: late ack is dropped
        hblank = 1'b1; vblank = 1'b1;
        check("wait_state", 32'(dut.state), 32'(WAIT));
        check("wait_req", 32'(mem_req), 32'd1);
        vs = 1'b1; tick();
        vs = 1'b0; mem_word = 16'hFFFF; ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        check("late_ack_dropped", 32'(dut.fifo_count), 32'd0);
        tick();
        check("restart_req", 32'(mem_req), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'd0);
        check("restart_fifo", 32'(dut.fifo_count), 32'd0);

        // Disabled: no fetch, foreground passes, no underflow
        enable = 1'b0; tick();
        check("dis_req", 32'(mem_req), 32'd0);
        check("dis_state", 32'(dut.state), 32'(IDLE));
        mode = 2'd3; fg_rgb = 12'h321; hblank = 1'b0; vblank = 1'b0; ce_pix = 1'b1;
        tick();
        ce_pix = 1'b0; hblank = 1'b1; vblank = 1'b1;
        check("dis_rgb", 32'(rgb_out), 32'h321);
        check("dis_underflow", 32'(underflow), 32'd0);
        check("dis_cnt", 32'(underflow_cnt), 32'd255);

        // Asynchronous reset clears without a clock edge
        #2 RESET_L = 1'b0;
        #1;
        check("async_rst_cnt", 32'(underflow_cnt), 32'd0);
        check("async_rst_rgb", 32'(rgb_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bg_overlay_fetch.md
BG_OVERLAY_FETCH -- requirements
Module: bg_overlay_fetch

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL have parameter CW, default 4, range 4..8: output bits per colour channel.
REQ-004 SHALL have parameter DEPTH, default 16, power of 2 and at least 4: prefetch FIFO depth in words.
REQ-005 SHALL have parameter ADDR_W, default 25: memory byte-address width.
REQ-006 SHALL have parameter BASE_ADDR, default 0: frame start byte address.
REQ-007 SHALL have the ports below; the clock is single and the reset is asynchronous, active-low:
- clk_sys in 1: the only clock.
- RESET_L in 1: asynchronous, active-low reset.
- ce_pix in 1: pixel enable.
- hblank in 1: horizontal blank.
- vblank in 1: vertical blank.
- vs in 1: vertical sync, active high.
- enable in 1: background in use.
- mode in 2: composite mode.
- fg_rgb in 3*CW: foreground pixel, {R,G,B}.
- mem_req out 1: read request.
- mem_addr out ADDR_W: read byte address.
- mem_ack in 1: read data valid.
- mem_data in 16: background word, {B,A,R,G}, 4 bits each.
- rgb_out out 3*CW: composited pixel.
- underflow out 1: single-cycle underflow pulse.
- underflow_cnt out 8: saturating underflow count.

Function
REQ-008 Handshake: mem_req SHALL be held high with mem_addr stable until the cycle mem_ack=1; mem_data is sampled in that cycle; at most one request is outstanding.
REQ-009 Fetch FSM SHALL have states IDLE, FETCH, WAIT, DONE.
- IDLE->FETCH: enable=1 and rising edge of vs.
- FETCH->WAIT: request issued when FIFO count plus outstanding requests < DEPTH.
- WAIT->FETCH: on mem_ack.
- FETCH->DONE: after H_ACTIVE*V_ACTIVE words have been requested.
- DONE->FETCH: next rising edge of vs.
- Any state->IDLE: enable=0.
REQ-010 mem_addr SHALL start at BASE_ADDR and advance by 2 per acknowledged word, wrapping modulo 2^ADDR_W.
REQ-011 A rising edge of vs (vs high, previous sampled value low) SHALL flush the FIFO, reload the address and reset the word counter in the same cycle; a request outstanding at that edge completes its handshake and its data is discarded.
REQ-012 FIFO write SHALL occur on a non-discarded mem_ack; a write to a full FIFO cannot occur per REQ-009.
REQ-013 On ce_pix=1 with hblank=0 and vblank=0, one word SHALL be popped.
- If the FIFO is empty: the background is treated as zero, underflow pulses for one cycle, and underflow_cnt increments, saturating at 255.
REQ-014 Each 4-bit channel SHALL expand to CW bits by MSB replication; alpha stays 4 bits.
REQ-015 Composite output SHALL be registered, updated only on ce_pix, with one ce_pix of latency. By mode:
- 0: fg.
- 1: fg if fg is nonzero and a=0, else bg.
- 2: per channel (fg*(16-a) + bg*a) >> 4, with a 0..15, intermediate CW+5 bits, no overflow.
- 3: bg.
REQ-016 When hblank or vblank is high at ce_pix, rgb_out SHALL be 0 and no pop SHALL occur.
REQ-017 When enable=0, the background SHALL be treated as zero, there is no fetching and no underflow reporting, and mode 0 applies.
REQ-018 A simultaneous pop and push SHALL leave the FIFO count unchanged; a simultaneous rising edge of vs and pop SHALL give flush priority.

Reset
REQ-019 While RESET_L=0, the module SHALL hold this reset state:
- FSM: IDLE.
- mem_req: 0.
- mem_addr: BASE_ADDR.
- FIFO: empty.
- rgb_out: 0.
- underflow: 0.
- underflow_cnt: 0.
- Previous vs: 0.
- Discard flag: clear.
REQ-020 A reset asserted mid-request SHALL drop the request; the memory controller tolerates an abandoned request.

Structure
REQ-021 Package bg_ovl_pkg SHALL hold:
- The mode enum (MODE_FG, MODE_KEY, MODE_BLEND, MODE_BG).
- The FSM state enum.
- Bit positions of the B/A/R/G fields in the 16-bit word.
REQ-022 A single sub-module bg_fifo SHALL implement the synchronous FIFO (parameters DEPTH and width 16, with count, full and empty outputs).

Verification
REQ-023 Reset, then enable=1 and a vs rising edge: first request at BASE_ADDR, subsequent addresses 2, 4, 6; the FIFO fills to 16 and requests stall.
REQ-024 Memory returns 0xF0F0 (B=F, A=0, R=F, G=0), fg=0, mode 1: rgb_out = {F,0,F} one ce_pix after the active pixel.
REQ-025 Mode 2, fg={8,8,8}, word with A=8 and R=G=B=0: rgb_out = {4,4,4}.
REQ-026 mem_ack withheld for 40 active pixels: the FIFO drains; underflow pulses once per empty pop; underflow_cnt reaches 24; the count saturates at 255 under a longer stall.
REQ-027 vs rising edge while in WAIT: the late ack is discarded; the next request is at BASE_ADDR; the FIFO is empty.
REQ-028 H_ACTIVE=4, V_ACTIVE=2: exactly 8 words are requested, then the FSM is in DONE with mem_req=0 until the next vs.
